// File: rtl/regfile_dump_reader_if.sv
// Bundle of control, register-file read-port and output-stream signals for
// the register-file dump engine. The master side is the dump engine itself;
// the slave side is whatever drives start, answers reads and consumes beats.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  start,
    output busy,
    output done,
    output rd_addr1,
    output rd_addr2,
    input  rd_data1,
    input  rd_data2,
    output out_valid,
    input  out_ready,
    output out_index,
    output out_data
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  rd_addr1,
    input  rd_addr2,
    output rd_data1,
    output rd_data2,
    input  out_valid,
    output out_ready,
    input  out_index,
    input  out_data
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: on start, fetches the architectural registers
// two at a time through the register file's read ports and streams them out
// in index order as valid/ready (index, data) beats. Every output is decoded
// from registered state, so neither start nor out_ready reaches an output
// combinationally.
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_dump_reader_if.master  dump_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPT    = 3'd2,
    S_EMIT_LO = 3'd3,
    S_EMIT_HI = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int JW = ADDR_W - 1;
  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [JW-1:0] J_ONE  = {{(JW-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [JW-1:0]     j_q, j_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;

  // State, pair counter and captured pair; everything clears on reset,
  // including the data buffers, so an aborted dump leaves no stale beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state logic: fetch a pair (ISSUE, CAPT), emit low then high beat,
  // advance to the next pair or finish after the last one.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      S_IDLE: begin
        if (dump_if.start) begin
          j_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        // Read data reflects the addresses sampled at the ISSUE edge.
        lo_d    = dump_if.rd_data1;
        hi_d    = dump_if.rd_data2;
        state_d = S_EMIT_LO;
      end
      S_EMIT_LO: begin
        if (dump_if.out_ready) begin
          state_d = S_EMIT_HI;
        end
      end
      S_EMIT_HI: begin
        if (dump_if.out_ready) begin
          if (j_q == J_LAST) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + J_ONE;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state; addresses drive the read ports only
  // while a pair is being fetched and sit at zero otherwise.
  always_comb begin
    dump_if.busy      = 1'b0;
    dump_if.done      = 1'b0;
    dump_if.rd_addr1  = '0;
    dump_if.rd_addr2  = '0;
    dump_if.out_valid = 1'b0;
    dump_if.out_index = '0;
    dump_if.out_data  = '0;
    unique case (state_q)
      S_ISSUE, S_CAPT: begin
        dump_if.busy     = 1'b1;
        dump_if.rd_addr1 = {j_q, 1'b0};
        dump_if.rd_addr2 = {j_q, 1'b1};
      end
      S_EMIT_LO: begin
        dump_if.busy      = 1'b1;
        dump_if.out_valid = 1'b1;
        dump_if.out_index = {j_q, 1'b0};
        dump_if.out_data  = lo_q;
      end
      S_EMIT_HI: begin
        dump_if.busy      = 1'b1;
        dump_if.out_valid = 1'b1;
        dump_if.out_index = {j_q, 1'b1};
        dump_if.out_data  = hi_q;
      end
      S_DONE: begin
        dump_if.done = 1'b1;
      end
      default: begin
        dump_if.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for the register-file dump engine: a register-file model with a
// registered read port, a beat-level reference model of the dump, directed
// scenarios with literal expectations and randomized dumps.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  logic reset;

  regfile_dump_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dif ();

  regfile_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .dump_if (dif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: owned by the stimulus process.
  logic [DATA_W-1:0] rf_regs [NREG];

  // Registered read port; read data only updates when an address is nonzero.
  always @(posedge clk) begin
    if (dif.rd_addr1 != '0 || dif.rd_addr2 != '0) begin
      dif.rd_data1 <= rf_regs[dif.rd_addr1];
      dif.rd_data2 <= rf_regs[dif.rd_addr2];
    end
  end

  // Write notifications from the stimulus to the model.
  int                wr_seq = 0;
  int                wr_reg = 0;
  logic [DATA_W-1:0] wr_val = '0;

  // Model state, owned by the compare process.
  bit                m_active = 0;
  bit                m_done_now = 0;
  bit                rst_seen = 0;
  int                m_next = 0;
  logic [DATA_W-1:0] exp_val [NREG];
  logic [DATA_W-1:0] got_data [NREG];
  int                t_start = 0, t_first = 0, t_done = 0, stalls = 0, done_cnt = 0;
  bit                first_seen = 0;
  bit                prev_valid = 0, prev_ready = 0;
  logic [ADDR_W-1:0] prev_idx = '0;
  logic [DATA_W-1:0] prev_data = '0;
  int                wr_seen = 0;

  function automatic logic [DATA_W-1:0] init_val(input int r);
    case (r)
      8:  return 32'd10;
      9:  return 32'd20;
      10: return 32'd22;
      11: return 32'd40;
      12: return 32'd50;
      13: return 32'd60;
      14: return 32'd70;
      15: return 32'd80;
      16: return 32'd1;
      17: return 32'd2;
      18: return 32'd0;
      19: return 32'd4;
      20: return 32'd5;
      21: return 32'd6;
      22: return 32'd7;
      23: return 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: checks outputs every cycle, then advances the model
  // using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin : cmp_blk
    bit idle;
    if (rst_seen) begin
      chk("rst_busy",  dif.busy, 0);
      chk("rst_done",  dif.done, 0);
      chk("rst_valid", dif.out_valid, 0);
      chk("rst_index", dif.out_index, 0);
      chk("rst_data",  dif.out_data, 0);
      chk("rst_addr1", dif.rd_addr1, 0);
      chk("rst_addr2", dif.rd_addr2, 0);
    end else begin
      chk("busy", dif.busy, m_active);
      chk("done", dif.done, m_done_now);
      if (dif.out_valid) chk("valid_in_dump", m_active, 1);
      if (m_active && !dif.out_valid) begin
        chk("fetch_addr1", dif.rd_addr1, m_next);
        chk("fetch_addr2", dif.rd_addr2, m_next + 1);
      end else begin
        chk("quiet_addr1", dif.rd_addr1, 0);
        chk("quiet_addr2", dif.rd_addr2, 0);
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", dif.out_valid, 1);
        chk("hold_index", dif.out_index, prev_idx);
        chk("hold_data",  dif.out_data, prev_data);
      end
      if (dif.done) begin
        t_done = cyc;
        done_cnt++;
      end
      if (m_active && dif.out_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          t_first = cyc;
        end
        if (!dif.out_ready) stalls++;
      end
    end

    // A register written while pair p is on the output shows its new value
    // only if its own pair has not been fetched yet.
    if (wr_seq != wr_seen) begin
      wr_seen = wr_seq;
      if (m_active && (wr_reg / 2) > (m_next / 2)) exp_val[wr_reg] = wr_val;
    end

    idle = !m_active && !m_done_now;
    m_done_now = 0;
    if (reset) begin
      m_active   = 0;
      m_next     = 0;
      rst_seen   = 1;
      prev_valid = 0;
      prev_ready = 0;
    end else begin
      rst_seen = 0;
      if (m_active && dif.out_valid && dif.out_ready) begin
        chk("beat_index", dif.out_index, m_next);
        chk("beat_data",  dif.out_data, exp_val[m_next]);
        got_data[m_next] = dif.out_data;
        m_next++;
        if (m_next == NREG) begin
          m_active   = 0;
          m_done_now = 1;
        end
      end else if (idle && dif.start) begin
        m_active   = 1;
        m_next     = 0;
        t_start    = cyc;
        first_seen = 0;
        stalls     = 0;
        for (int i = 0; i < NREG; i++) exp_val[i] = rf_regs[i];
      end
      prev_valid = dif.out_valid;
      prev_ready = dif.out_ready;
      prev_idx   = dif.out_index;
      prev_data  = dif.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int r, input logic [DATA_W-1:0] v);
    rf_regs[r] = v;
    wr_reg     = r;
    wr_val     = v;
    wr_seq++;
  endtask

  // One dump from a start pulse until done (or until an injected reset).
  task automatic run_dump(input int ready_pct, input int bp_idx, input logic [DATA_W-1:0] bp_data,
                          input bit repulse, input int rst_idx,
                          input int wr_idx, input int wr_r, input logic [DATA_W-1:0] wr_v,
                          input bit rand_wr);
    int guard, stall_left, d0;
    bit bp_done, rp3, rp20, wr_done, fin;
    d0 = done_cnt; guard = 0; stall_left = 0;
    bp_done = 0; rp3 = 0; rp20 = 0; wr_done = 0; fin = 0;
    dif.start     = 1'b1;
    dif.out_ready = ($urandom_range(99) < ready_pct);
    tick();
    while (!fin && guard < 600) begin
      dif.start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        fin   = 1;
      end else begin
        if (stall_left > 0) begin
          dif.out_ready = 1'b0;
          stall_left--;
          chk("bp_hold_index", dif.out_index, bp_idx);
          chk("bp_hold_data",  dif.out_data, bp_data);
        end else if (bp_idx >= 0 && !bp_done && dif.out_valid && dif.out_index == bp_idx) begin
          dif.out_ready = 1'b0;
          stall_left    = 4;
          bp_done       = 1;
          chk("bp_first_data", dif.out_data, bp_data);
        end else begin
          dif.out_ready = ($urandom_range(99) < ready_pct);
        end
        if (repulse && dif.out_valid) begin
          if (dif.out_index == 3 && !rp3) begin
            dif.start = 1'b1; rp3 = 1;
          end else if (dif.out_index == 20 && !rp20) begin
            dif.start = 1'b1; rp20 = 1;
          end
        end
        if (rst_idx >= 0 && dif.out_valid && dif.out_index == rst_idx) reset = 1'b1;
        if (wr_idx >= 0 && !wr_done && dif.out_valid && dif.out_index == wr_idx) begin
          do_write(wr_r, wr_v);
          wr_done = 1;
        end else if (rand_wr && dif.out_valid && $urandom_range(9) == 0) begin
          do_write($urandom_range(31, 1), $urandom);
        end
      end
      tick();
      guard++;
      if (done_cnt != d0) fin = 1;
    end
    dif.start     = 1'b0;
    dif.out_ready = 1'b1;
    chk("dump_finished", fin, 1);
  endtask

  initial begin
    int d0;
    reset         = 1'b1;
    dif.start     = 1'b0;
    dif.out_ready = 1'b1;
    for (int r = 0; r < NREG; r++) rf_regs[r] = init_val(r);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Plain dump of the freshly reset register file.
    d0 = done_cnt;
    run_dump(100, -1, 0, 0, -1, -1, 0, 0, 0);
    chk("A_first_latency", t_first - t_start, 3);
    chk("A_done_latency",  t_done - t_start, 65);
    chk("A_beats",   m_next, 32);
    chk("A_dones",   done_cnt - d0, 1);
    chk("A_beat7",   got_data[7], 0);
    chk("A_beat8",   got_data[8], 10);
    chk("A_beat9",   got_data[9], 20);
    chk("A_beat16",  got_data[16], 1);
    chk("A_beat23",  got_data[23], 8);
    chk("A_beat31",  got_data[31], 0);

    // Backpressure on index 9 for five cycles.
    run_dump(100, 9, 32'd20, 0, -1, -1, 0, 0, 0);
    chk("B_done_latency", t_done - t_start, 70);
    chk("B_stalls",  stalls, 5);
    chk("B_beat10",  got_data[10], 22);

    // Start re-pulsed mid-dump is ignored.
    d0 = done_cnt;
    run_dump(100, -1, 0, 1, -1, -1, 0, 0, 0);
    repeat (4) tick();
    chk("C_dones", done_cnt - d0, 1);
    chk("C_beats", m_next, 32);
    chk("C_done_latency", t_done - t_start, 65);

    // Reset while index 12 is on the output, then a clean restart.
    run_dump(100, -1, 0, 0, 12, -1, 0, 0, 0);
    tick();
    d0 = done_cnt;
    run_dump(100, -1, 0, 0, -1, -1, 0, 0, 0);
    chk("D_dones", done_cnt - d0, 1);
    chk("D_done_latency", t_done - t_start, 65);
    chk("D_beat12", got_data[12], 50);

    // Datapath write to reg 20 well before pair 10 is fetched.
    run_dump(100, -1, 0, 0, -1, 5, 20, 32'd99, 0);
    chk("E_beat20", got_data[20], 99);
    chk("E_beat21", got_data[21], 6);

    // Randomized contents, backpressure, writes and stray start pulses.
    for (int k = 0; k < 5; k++) begin
      rf_regs[0] = '0;
      for (int r = 1; r < NREG; r++) rf_regs[r] = $urandom;
      d0 = done_cnt;
      run_dump(60, -1, 0, 1, -1, -1, 0, 0, 1);
      chk("R_latency", t_done - t_start, 65 + stalls);
      chk("R_dones",   done_cnt - d0, 1);
      repeat ($urandom_range(3)) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
